// File: rtl/pipelined_adder_sub_if.sv
// Operand/result handshake bundle for pipelined_adder_sub.
// The slave side is the adder; the master side is the producer/consumer pair.
interface pipelined_adder_sub_if #(
    parameter int WIDTH = 32
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             overflow;

    modport master (
        output in_valid, a, b, c_in, sub, out_ready,
        input  in_ready, out_valid, sum, c_out, overflow
    );

    modport slave (
        input  in_valid, a, b, c_in, sub, out_ready,
        output in_ready, out_valid, sum, c_out, overflow
    );
endinterface

// File: rtl/pipelined_adder_sub.sv
// Pipelined adder/subtractor: ripple carry resolved CHUNK bits per stage,
// valid/ready handshake with a global stall enable across all stages.
module pipelined_adder_sub #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    pipelined_adder_sub_if.slave  bus
);
    localparam int CHUNK_SAFE = (CHUNK < 1) ? 1 : CHUNK;
    localparam int NSTG       = WIDTH / CHUNK_SAFE;

    if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK_SAFE) != 0) begin : g_param_err
        $error("pipelined_adder_sub: WIDTH must be >= 1 and a multiple of CHUNK");
    end

    logic stall;
    logic adv;
    logic accept;
    logic ovf_q;

    assign stall        = bus.out_valid && !bus.out_ready;
    assign adv          = !stall;
    assign accept       = bus.in_valid && adv;
    assign bus.in_ready = adv;

    // Stage gi holds the result with its low gi*CHUNK bits resolved and the
    // remaining high bits still equal to operand A; B' shrinks as slices retire.
    genvar gi;
    for (gi = 0; gi <= NSTG; gi++) begin : g_stg
        logic             valid_q;
        logic [WIDTH-1:0] a_q;
        logic             c_q;

        if (gi == 0) begin : g_cap
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    valid_q <= 1'b0;
                    a_q     <= '0;
                    c_q     <= 1'b0;
                end else if (adv) begin
                    valid_q <= accept;
                    if (accept) begin
                        a_q <= bus.a;
                        c_q <= bus.c_in ^ bus.sub;
                    end
                end
            end
        end else begin : g_add
            logic [CHUNK-1:0] sa;
            logic [CHUNK-1:0] sb;
            logic [CHUNK:0]   ss;
            logic [WIDTH-1:0] a_d;

            assign sa = g_stg[gi-1].a_q[(gi-1)*CHUNK +: CHUNK];
            assign sb = g_stg[gi-1].g_b.b_q[CHUNK-1:0];
            assign ss = {1'b0, sa} + {1'b0, sb} + {{CHUNK{1'b0}}, g_stg[gi-1].c_q};

            always_comb begin
                a_d = g_stg[gi-1].a_q;
                a_d[(gi-1)*CHUNK +: CHUNK] = ss[CHUNK-1:0];
            end

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    valid_q <= 1'b0;
                    a_q     <= '0;
                    c_q     <= 1'b0;
                end else if (adv) begin
                    valid_q <= g_stg[gi-1].valid_q;
                    if (g_stg[gi-1].valid_q) begin
                        a_q <= a_d;
                        c_q <= ss[CHUNK];
                    end
                end
            end

            if (gi == NSTG) begin : g_ovf
                logic ovf_d;
                // Carry into the MSB is recovered from the MSB sum bit itself.
                assign ovf_d = ss[CHUNK-1] ^ sa[CHUNK-1] ^ sb[CHUNK-1] ^ ss[CHUNK];

                always_ff @(posedge clk_i or negedge rst_ni) begin
                    if (!rst_ni) begin
                        ovf_q <= 1'b0;
                    end else if (adv && g_stg[gi-1].valid_q) begin
                        ovf_q <= ovf_d;
                    end
                end
            end
        end

        if (gi < NSTG) begin : g_b
            logic [WIDTH-gi*CHUNK-1:0] b_q;

            if (gi == 0) begin : g_b_cap
                always_ff @(posedge clk_i or negedge rst_ni) begin
                    if (!rst_ni) begin
                        b_q <= '0;
                    end else if (accept) begin
                        b_q <= bus.sub ? ~bus.b : bus.b;
                    end
                end
            end else begin : g_b_fwd
                always_ff @(posedge clk_i or negedge rst_ni) begin
                    if (!rst_ni) begin
                        b_q <= '0;
                    end else if (adv && g_stg[gi-1].valid_q) begin
                        b_q <= g_stg[gi-1].g_b.b_q[WIDTH-(gi-1)*CHUNK-1:CHUNK];
                    end
                end
            end
        end
    end

    assign bus.out_valid = g_stg[NSTG].valid_q;
    assign bus.sum       = g_stg[NSTG].a_q;
    assign bus.c_out     = g_stg[NSTG].c_q;
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_pipelined_adder_sub.sv
// Bench for pipelined_adder_sub: arithmetic model + scoreboard queue checked every
// cycle, with directed latency/stall/reset cases and a 4-bit single-stage instance.
module tb_pipelined_adder_sub;
    typedef struct packed {
        logic [31:0] s;
        logic        c;
        logic        o;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    logic rand_rdy = 1'b0;
    exp_t q[$];
    int   take_cyc[$];

    pipelined_adder_sub_if #(.WIDTH(32)) bus ();
    pipelined_adder_sub_if #(.WIDTH(4))  bus4 ();

    pipelined_adder_sub #(.WIDTH(32), .CHUNK(8)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    pipelined_adder_sub #(.WIDTH(4), .CHUNK(4)) dut4 (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus4)
    );

    always #5 clk = ~clk;

    initial begin : cyc_count
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Result from signed/unsigned integer arithmetic, not from carry chains.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic cin, input logic sub);
        exp_t   e;
        longint sr;
        longint ua;
        longint ub;
        longint ci;
        ua = longint'(a);
        ub = longint'(b);
        ci = longint'(cin);
        if (sub) sr = longint'($signed(a)) - longint'($signed(b)) - ci;
        else     sr = longint'($signed(a)) + longint'($signed(b)) + ci;
        e.s = sr[31:0];
        e.c = sub ? (ua >= ub + ci) : ((ua + ub + ci) >= 64'sd4294967296);
        e.o = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        return e;
    endfunction

    // Scoreboard: push on accept, pop on take, hold check while stalled.
    initial begin : cmp
        exp_t e;
        exp_t prev;
        logic stalled;
        stalled = 1'b0;
        prev    = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                q.delete();
                stalled = 1'b0;
            end else begin
                if (stalled)
                    chk("hold", {bus.out_valid, bus.sum, bus.c_out, bus.overflow}, {1'b1, prev});
                chk("in_ready", bus.in_ready, !(bus.out_valid && !bus.out_ready));
                if (bus.out_valid) begin
                    if (q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL spurious_out_valid: got out_valid=1 expected no pending result (cycle %0d)", cyc);
                    end else if (bus.out_ready) begin
                        e = q.pop_front();
                        chk("result", {bus.sum, bus.c_out, bus.overflow}, e);
                        take_cyc.push_back(cyc);
                    end
                end
                if (bus.in_valid && bus.in_ready)
                    q.push_back(model(bus.a, bus.b, bus.c_in, bus.sub));
                stalled = bus.out_valid && !bus.out_ready;
                prev    = {bus.sum, bus.c_out, bus.overflow};
            end
        end
    end

    initial begin : rdy_rand
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) bus.out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.c_in     = cin;
        bus.sub      = sub;
        @(negedge clk);
        while (!bus.in_ready && n < 60) begin
            n++;
            @(negedge clk);
        end
        if (n >= 60) chk("send_timeout", 1'b0, 1'b1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(name, q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin : main
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.c_in      = 1'b0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b1;
        bus4.in_valid  = 1'b0;
        bus4.a         = '0;
        bus4.b         = '0;
        bus4.c_in      = 1'b0;
        bus4.sub       = 1'b0;
        bus4.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_sum", bus.sum, 32'h0);
        chk("rst_c_out", bus.c_out, 1'b0);
        chk("rst_overflow", bus.overflow, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", bus.in_ready, 1'b1);
        chk("idle_out_valid", bus.out_valid, 1'b0);
        @(posedge clk);
        #1;

        // Test 1: latency of exactly NSTG=4 edges after capture
        send(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
        repeat (4) begin
            @(negedge clk);
            chk("t1_not_yet_valid", bus.out_valid, 1'b0);
        end
        @(negedge clk);
        chk("t1_valid", bus.out_valid, 1'b1);
        chk("t1_sum", bus.sum, 32'h0);
        chk("t1_c_out", bus.c_out, 1'b1);
        chk("t1_ovf", bus.overflow, 1'b0);
        drain("t1_drain");

        // Test 2: signed overflow, then subtract with borrow-in
        send(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
        send(32'h5, 32'h7, 1'b1, 1'b1);
        while (!bus.out_valid) @(negedge clk);
        chk("t2a_sum", bus.sum, 32'h8000_0000);
        chk("t2a_c_out", bus.c_out, 1'b0);
        chk("t2a_ovf", bus.overflow, 1'b1);
        @(negedge clk);
        chk("t2b_valid", bus.out_valid, 1'b1);
        chk("t2b_sum", bus.sum, 32'hFFFF_FFFD);
        chk("t2b_c_out", bus.c_out, 1'b0);
        chk("t2b_ovf", bus.overflow, 1'b0);
        drain("t2_drain");

        // Test 3: 16 random back-to-back, one result per cycle
        take_cyc.delete();
        for (int i = 0; i < 16; i++)
            send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        drain("t3_drain");
        chk("t3_count", take_cyc.size(), 16);
        if (take_cyc.size() == 16)
            chk("t3_rate", take_cyc[15] - take_cyc[0], 15);

        // Test 4: fill the pipe under backpressure, then release
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        repeat (3) begin
            @(negedge clk);
            chk("t4_in_ready_low", bus.in_ready, 1'b0);
            chk("t4_out_valid_high", bus.out_valid, 1'b1);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        drain("t4_drain");

        // Random backpressure with random operands
        rand_rdy = 1'b1;
        for (int i = 0; i < 30; i++)
            send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        rand_rdy = 1'b0;
        bus.out_ready = 1'b1;
        drain("rand_drain");

        // Test 5: reset with three operands in flight
        for (int i = 0; i < 3; i++)
            send($urandom, $urandom, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("t5_out_valid", bus.out_valid, 1'b0);
        chk("t5_sum", bus.sum, 32'h0);
        chk("t5_c_out", bus.c_out, 1'b0);
        chk("t5_ovf", bus.overflow, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            chk("t5_no_valid", bus.out_valid, 1'b0);
        end
        @(posedge clk);
        #1;

        // Test 6: WIDTH=4, CHUNK=4 single-stage instance
        bus4.in_valid = 1'b1;
        bus4.a        = 4'd9;
        bus4.b        = 4'd8;
        bus4.c_in     = 1'b1;
        bus4.sub      = 1'b0;
        @(negedge clk);
        chk("t6_in_ready", bus4.in_ready, 1'b1);
        @(posedge clk);
        #1;
        bus4.in_valid = 1'b0;
        @(negedge clk);
        chk("t6_not_yet_valid", bus4.out_valid, 1'b0);
        @(negedge clk);
        chk("t6_valid", bus4.out_valid, 1'b1);
        chk("t6_sum", bus4.sum, 4'd2);
        chk("t6_c_out", bus4.c_out, 1'b1);
        chk("t6_ovf", bus4.overflow, 1'b1);
        @(negedge clk);
        chk("t6_valid_falls", bus4.out_valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
